keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Parametrised matrix-keypad scanner: drives one-hot columns, synchronises and debounces rows, and
//  emits one key-press event per debounced press over a valid/ready handshake. Also drives a 7-seg
//  display of the last accepted key. Sits between the board keypad pins and the user logic.
// PARAMETERS
//  ROWS      4   keypad rows (2..8)
//  COLS      4   keypad columns (2..8)
//  SCAN_DIV  1000  clk cycles each column is driven (>=3)
//  DEBOUNCE  4   consecutive identical frames required to accept a state (>=1)
//  KEY_W     $clog2(ROWS*COLS)  key code width (derived, localparam)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  row        in   ROWS   raw row sense lines, active-high, asynchronous to clk
//  col        out  COLS   one-hot column drive, active-high
//  key_valid  out  1      press event pending
//  key_ready  in   1      consumer accepts event when key_valid&&key_ready
//  key_code   out  KEY_W  code of pending/last event = row_idx*COLS + col_idx
//  key_down   out  1      level: debounced key currently held
//  overflow   out  1      sticky: event dropped while key_valid pending
//  ovf_clr    in   1      synchronous clear of overflow
//  segment    out  8      {a,b,c,d,e,f,g,dp} active-high, hex glyph of last accepted key
// BEHAVIOUR
//  Reset (async assert, sync release): col=1 (column 0), key_valid=0, key_code=0, key_down=0,
//   overflow=0, segment=8'h00 (blank), scan counters=0, debounce state = NONE.
//  Scan: col advances col0->col1->..->col[COLS-1]->col0 every SCAN_DIV cycles. Frame = COLS*SCAN_DIV.
//  row passes a 2-flop synchroniser; sample taken on the LAST cycle of each column dwell only.
//  Per frame, candidate = lowest code among pressed positions (row-major, lowest row then lowest col);
//   no position pressed -> NONE. Multiple keys: lowest code wins, no error.
//  Debounce: candidate equal for DEBOUNCE consecutive frames -> becomes accepted state; any differing
//   frame restarts the count at 1 with the new candidate. Count saturates.
//  Acceptance, evaluated the cycle after the frame's final sample:
//   NONE->K or K1->K2 (K2!=K1): key_down=1; event K generated; segment=glyph(K).
//   K->NONE: key_down=0; no event; segment holds last glyph.
//   Same accepted state again: nothing.
//  Handshake: event with key_valid=0 -> key_valid=1, key_code=K next cycle. key_valid/key_code hold
//   stable until key_valid&&key_ready; key_valid drops the following cycle. Event arriving while
//   key_valid=1 (incl. the cycle handshake completes) -> dropped, overflow=1; pending event unchanged.
//  ovf_clr=1 clears overflow next cycle; a simultaneous drop wins (overflow stays 1).
//  Latency: stable press from first sampled frame -> key_valid after DEBOUNCE frames + 1 cycle.
//  key_code for ROWS*COLS < 2**KEY_W never exceeds ROWS*COLS-1; glyph of codes >15 = 8'h02 (dp only).
//  Reset mid-scan/mid-handshake: everything returns to reset values; pending event discarded.
// STRUCTURE
//  Shared package keypad_pkg: SEG_* glyph constants for 0-F (0=8'hFC, 1=8'h60, ... F=8'h8E),
//   SEG_BLANK=8'h00, SEG_ERR=8'h02, and the key_state struct {logic none; logic [KEY_W-1:0] code}.
//  One sub-module: seg7_hex_decoder (combinational code->glyph, registered in this block).
//  Blocks here: column ring counter + dwell counter, synchroniser, frame candidate reg,
//   debounce counter, 1-entry event register + overflow flag.
// TESTING  (bench: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2; frame=16 cycles)
//  1 Reset: rst_n=0 mid-frame -> col=4'b0001, key_valid=0, segment=8'h00, overflow=0 immediately.
//  2 Hold row1 when col=4'b0010 for 3 frames -> one event key_code=5, key_down=1, segment=8'hB6.
//  3 Glitch: key 9 present 1 frame only -> no event, key_down stays 0.
//  4 key_ready=0; press 3, release, press 7 -> key_code=3 stays valid, overflow=1; ovf_clr -> 0.
//  5 Hold 2 and B together -> code 2 event; release 2 keeping B -> event code 11, segment=8'h3E.
//  6 Release after key 0 accepted -> key_down=0 after 2 frames, no event, segment stays 8'hFC.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared glyph constants and key state type for the keypad scanner
package keypad_pkg;

  // Wide enough for the largest supported 8x8 matrix; narrower keypads zero the upper bits.
  localparam int KEY_W_MAX = 6;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ERR   = 8'h02;

  typedef struct packed {
    logic                 none;
    logic [KEY_W_MAX-1:0] code;
  } key_state_t;

  localparam key_state_t KEY_NONE = '{none: 1'b1, code: '0};

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational key code to {a..g,dp} hex glyph
module seg7_hex_decoder
  import keypad_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] code,
  output logic [7:0]   glyph
);

  logic [KEY_W_MAX-1:0] code_ext;

  always_comb begin
    code_ext = KEY_W_MAX'(code);
    case (code_ext)
      6'd0:    glyph = SEG_0;
      6'd1:    glyph = SEG_1;
      6'd2:    glyph = SEG_2;
      6'd3:    glyph = SEG_3;
      6'd4:    glyph = SEG_4;
      6'd5:    glyph = SEG_5;
      6'd6:    glyph = SEG_6;
      6'd7:    glyph = SEG_7;
      6'd8:    glyph = SEG_8;
      6'd9:    glyph = SEG_9;
      6'd10:   glyph = SEG_A;
      6'd11:   glyph = SEG_B;
      6'd12:   glyph = SEG_C;
      6'd13:   glyph = SEG_D;
      6'd14:   glyph = SEG_E;
      6'd15:   glyph = SEG_F;
      default: glyph = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - matrix keypad scanner with debounce, press events and 7-seg output
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int KEY_W   = $clog2(ROWS*COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  col,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_code,
  output logic             key_down,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [7:0]       segment
);

  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);

  logic [DW-1:0]   dcnt;
  logic [CW-1:0]   cidx;
  logic [ROWS-1:0] row_s1, row_s2;
  logic            sample, last_col, frame_pulse;
  key_state_t      col_hit, merged, frame_acc, frame_cand;
  key_state_t      db_cand, acc;
  logic [BW-1:0]   db_cnt, next_cnt;
  logic            accept, ev, drop;
  logic [7:0]      glyph;

  assign sample   = (dcnt == DW'(SCAN_DIV - 1));
  assign last_col = (cidx == CW'(COLS - 1));
  assign col      = COLS'(1) << cidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt   <= '0;
      cidx   <= '0;
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (sample) begin
        dcnt <= '0;
        cidx <= last_col ? '0 : cidx + 1'b1;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Lowest pressed row in the current column; iterate downward so the lowest row wins.
  always_comb begin
    col_hit = KEY_NONE;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_s2[r]) begin
        col_hit.none = 1'b0;
        col_hit.code = KEY_W_MAX'(r * COLS + int'(cidx));
      end
    end
  end

  always_comb begin
    merged = frame_acc;
    if (cidx == '0)
      merged = col_hit;
    else if (!col_hit.none && (frame_acc.none || col_hit.code < frame_acc.code))
      merged = col_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_acc   <= KEY_NONE;
      frame_cand  <= KEY_NONE;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= sample && last_col;
      if (sample)
        frame_acc <= merged;
      if (sample && last_col)
        frame_cand <= merged;
    end
  end

  always_comb begin
    if (frame_cand != db_cand)
      next_cnt = BW'(1);
    else if (db_cnt == BW'(DEBOUNCE))
      next_cnt = db_cnt;
    else
      next_cnt = db_cnt + 1'b1;
    accept = frame_pulse && (next_cnt == BW'(DEBOUNCE)) && (frame_cand != acc);
    ev     = accept && !frame_cand.none;
    drop   = ev && key_valid;
  end

  seg7_hex_decoder #(.W(KEY_W)) u_seg (
    .code  (frame_cand.code[KEY_W-1:0]),
    .glyph (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cand  <= KEY_NONE;
      db_cnt   <= '0;
      acc      <= KEY_NONE;
      key_down <= 1'b0;
      segment  <= SEG_BLANK;
    end else if (frame_pulse) begin
      db_cand <= frame_cand;
      db_cnt  <= next_cnt;
      if (accept) begin
        acc      <= frame_cand;
        key_down <= !frame_cand.none;
        if (ev)
          segment <= glyph;
      end
    end
  end

  // Single-entry event slot; an event that finds it occupied is lost and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (key_valid) begin
        if (key_ready)
          key_valid <= 1'b0;
      end else if (ev) begin
        key_valid <= 1'b1;
        key_code  <= frame_cand.code[KEY_W-1:0];
      end
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_down;
  logic        overflow;
  logic        ovf_clr;
  logic [7:0]  segment;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_down  (key_down),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .segment   (segment)
  );

  // Keypad matrix: a held key at (r,c) connects column c to row r.
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && col[c]) row[r] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * 16) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; keys = '0; key_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 32'(col), 32'h1);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_seg", 32'(segment), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("scan_col1", 32'(col), 32'h2);
    repeat (12) @(posedge clk);
    #1;
    check("scan_wrap", 32'(col), 32'h1);

    // Key 5: row 1 seen while column 1 driven
    keys = 16'(1) << 5;
    frames(4);
    check("k5_valid", 32'(key_valid), 32'h1);
    check("k5_code", 32'(key_code), 32'h5);
    check("k5_down", 32'(key_down), 32'h1);
    check("k5_seg", 32'(segment), 32'hB6);
    check("k5_ovf", 32'(overflow), 32'h0);
    consume();
    check("k5_drop", 32'(key_valid), 32'h0);
    frames(1);
    check("k5_single", 32'(key_valid), 32'h0);
    keys = '0;
    frames(4);
    check("k5_release", 32'(key_down), 32'h0);
    check("k5_seg_hold", 32'(segment), 32'hB6);

    // One-frame glitch on key 9
    keys = 16'(1) << 9;
    repeat (16) @(posedge clk);
    keys = '0;
    frames(4);
    check("glitch_valid", 32'(key_valid), 32'h0);
    check("glitch_down", 32'(key_down), 32'h0);
    check("glitch_seg", 32'(segment), 32'hB6);

    // Overflow: key 3 pending, key 7 arrives unconsumed
    keys = 16'(1) << 3;
    frames(4);
    check("k3_valid", 32'(key_valid), 32'h1);
    check("k3_code", 32'(key_code), 32'h3);
    keys = '0;
    frames(4);
    check("k3_release", 32'(key_down), 32'h0);
    keys = 16'(1) << 7;
    frames(4);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_code", 32'(key_code), 32'h3);
    check("ovf_valid", 32'(key_valid), 32'h1);
    check("ovf_seg", 32'(segment), 32'hE0);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);
    consume();
    check("ovf_consume", 32'(key_valid), 32'h0);
    keys = '0;
    frames(4);

    // Two keys: lowest code wins, then the survivor is reported
    keys = (16'(1) << 2) | (16'(1) << 11);
    frames(4);
    check("multi_code", 32'(key_code), 32'h2);
    check("multi_valid", 32'(key_valid), 32'h1);
    consume();
    keys = 16'(1) << 11;
    frames(4);
    check("kb_valid", 32'(key_valid), 32'h1);
    check("kb_code", 32'(key_code), 32'hB);
    check("kb_seg", 32'(segment), 32'h3E);
    consume();
    keys = '0;
    frames(4);

    // Key 0 then release: no release event, glyph kept
    keys = 16'h1;
    frames(4);
    check("k0_code", 32'(key_code), 32'h0);
    check("k0_seg", 32'(segment), 32'hFC);
    consume();
    keys = '0;
    repeat (8) @(posedge clk);
    #1;
    check("k0_still_down", 32'(key_down), 32'h1);
    frames(4);
    check("k0_up", 32'(key_down), 32'h0);
    check("k0_no_event", 32'(key_valid), 32'h0);
    check("k0_seg_hold", 32'(segment), 32'hFC);

    // Reset mid-frame with an event pending
    keys = 16'(1) << 5;
    frames(4);
    check("pre_rst_valid", 32'(key_valid), 32'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    keys = '0;
    #1;
    check("mid_rst_col", 32'(col), 32'h1);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_seg", 32'(segment), 32'h00);
    check("mid_rst_down", 32'(key_down), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    frames(2);
    check("post_rst_valid", 32'(key_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
